// File: rtl/legv8_mc_control_pkg.sv
// Shared opcode constants, ALU op encodings, FSM state and op-class types
// for the LEGv8 multicycle controller.
// Optional macro: BRANCH_EN adds the BRANCH state (CBZ / B support).
package legv8_ctrl_pkg;

  // Full 11-bit opcodes in IR[31:21]
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // Short-opcode formats: CB uses IR[31:24], B uses IR[31:26]
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  // ALU opcode driven on alu_op
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
`ifdef BRANCH_EN
    S_BRANCH = 3'd6,
`endif
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_ILLEGAL = 3'd0,
    OP_RTYPE   = 3'd1,
    OP_LDUR    = 3'd2,
    OP_STUR    = 3'd3,
    OP_CBZ     = 3'd4,
    OP_B       = 3'd5
  } op_class_t;

endpackage

// File: rtl/legv8_mc_control_if.sv
// Instruction and data memory handshake bundle for the LEGv8 controller.
// Handshake: a transfer completes on the rising edge where the request
// (imem_req, or dmem_rd/dmem_wr) and the matching ready are both high; the
// requester holds its request until then, and ready while the request is low
// carries no meaning. instr is only meaningful while imem_ready is high.
interface legv8_mc_control_if #(parameter int IW = 32);
  logic          imem_req;
  logic          imem_ready;
  logic [IW-1:0] instr;
  logic          dmem_rd;
  logic          dmem_wr;
  logic          dmem_ready;

  modport master (
    output imem_req, dmem_rd, dmem_wr,
    input  imem_ready, instr, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_rd, dmem_wr,
    output imem_ready, instr, dmem_ready
  );
endinterface

// File: rtl/legv8_mc_control_op_decode.sv
// Combinational opcode classifier: IR[31:21] in, instruction class out.
// Optional macro: BRANCH_EN enables CBZ / B classification; without it those
// encodings fall through to OP_ILLEGAL.
module legv8_op_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  // Classify the opcode field; anything unrecognised is illegal
  always_comb begin
    op_class = OP_ILLEGAL;
    if (opcode == OPC_AND || opcode == OPC_ORR ||
        opcode == OPC_ADD || opcode == OPC_SUB)
      op_class = OP_RTYPE;
    else if (opcode == OPC_LDUR)
      op_class = OP_LDUR;
    else if (opcode == OPC_STUR)
      op_class = OP_STUR;
`ifdef BRANCH_EN
    else if (opcode[10:3] == OPC_CBZ)
      op_class = OP_CBZ;
    else if (opcode[10:5] == OPC_B)
      op_class = OP_B;
`endif
  end

endmodule

// File: rtl/legv8_mc_control.sv
// LEGv8 multicycle control unit: Moore FSM sequencing fetch, decode,
// execute, memory, write-back and branch, with a sticky trap on bad opcodes.
// Optional macro: BRANCH_EN adds the BRANCH state; without it CBZ/B trap and
// pc_src is constant 0.
module legv8_mc_control
  import legv8_ctrl_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  legv8_mc_control_if.master        bus,
  input  logic                      zero,
  output logic [1:0]                alu_op,
  output logic [10:0]               alu_ctl,
  output logic                      alu_src,
  output logic                      reg2_loc,
  output logic                      reg_wr,
  output logic                      mem_to_reg,
  output logic                      pc_wr,
  output logic                      pc_src,
  output logic                      illegal,
  output state_t                    dbg_state
);

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] ir;
  op_class_t     op_class;
  logic          is_ldur;
  logic          is_stur;

  legv8_op_decode u_decode (
    .opcode   (ir[31:21]),
    .op_class (op_class)
  );

  assign is_ldur   = (op_class == OP_LDUR);
  assign is_stur   = (op_class == OP_STUR);
  assign dbg_state = state;

  // Operand/offset bits of IR are consumed by the datapath, not here
  logic unused_ir;
  assign unused_ir = ^ir[20:0];
`ifndef BRANCH_EN
  logic unused_zero;
  assign unused_zero = zero;
`endif

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Instruction register loads on the completing fetch edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ir <= '0;
    else if (state == S_FETCH && bus.imem_ready) ir <= bus.instr;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (bus.imem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op_class)
          OP_RTYPE, OP_LDUR, OP_STUR: next_state = S_EXEC;
`ifdef BRANCH_EN
          OP_CBZ, OP_B:               next_state = S_BRANCH;
`endif
          default:                    next_state = S_TRAP;
        endcase
      end
      S_EXEC:   next_state = (op_class == OP_RTYPE) ? S_WB : S_MEM;
      S_MEM:    if (bus.dmem_ready) next_state = is_ldur ? S_WB : S_FETCH;
      S_WB:     next_state = S_FETCH;
`ifdef BRANCH_EN
      S_BRANCH: next_state = S_FETCH;
`endif
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode from state and IR class. The STUR exit pc_wr follows
  // dmem_ready and the CBZ pc_src follows zero, since both only matter on
  // the edge that leaves the state.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_rd  = 1'b0;
    bus.dmem_wr  = 1'b0;
    alu_op       = ALU_ADD;
    alu_ctl      = '0;
    alu_src      = 1'b0;
    reg2_loc     = 1'b0;
    reg_wr       = 1'b0;
    mem_to_reg   = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_FETCH: bus.imem_req = 1'b1;
      S_EXEC: begin
        alu_ctl  = ir[31:21];
        reg2_loc = is_stur;
        if (op_class == OP_RTYPE) begin
          alu_op  = ALU_FUNCT;
          alu_src = 1'b0;
        end else begin
          alu_op  = ALU_ADD;
          alu_src = 1'b1;
        end
      end
      S_MEM: begin
        alu_ctl     = ir[31:21];
        alu_op      = ALU_ADD;
        alu_src     = 1'b1;
        reg2_loc    = is_stur;
        bus.dmem_rd = is_ldur;
        bus.dmem_wr = is_stur;
        pc_wr       = is_stur && bus.dmem_ready;
      end
      S_WB: begin
        reg_wr     = 1'b1;
        pc_wr      = 1'b1;
        mem_to_reg = is_ldur;
      end
`ifdef BRANCH_EN
      S_BRANCH: begin
        alu_op   = ALU_PASS_B;
        reg2_loc = 1'b1;
        pc_wr    = 1'b1;
        pc_src   = (op_class == OP_B) || (op_class == OP_CBZ && zero);
      end
`endif
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_legv8_mc_control.sv
// Self-checking bench for legv8_mc_control. Each instruction is run as a
// transaction; a class-level model predicts latency, handshake lengths and
// which control pulses must appear, and the observed trace is compared.
module tb_legv8_mc_control;
  import legv8_ctrl_pkg::*;

  localparam int C_ILL = 0;
  localparam int C_R   = 1;
  localparam int C_LD  = 2;
  localparam int C_ST  = 3;
  localparam int C_CBZ = 4;
  localparam int C_B   = 5;

  logic        clk;
  logic        rst_n;
  logic        zero_in;
  logic [1:0]  alu_op;
  logic [10:0] alu_ctl;
  logic        alu_src, reg2_loc, reg_wr, mem_to_reg, pc_wr, pc_src, illegal;
  state_t      dbg_state;

  int checks;
  int fails;

  legv8_mc_control_if #(.IW(32)) bus ();

  legv8_mc_control #(.IW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .zero       (zero_in),
    .alu_op     (alu_op),
    .alu_ctl    (alu_ctl),
    .alu_src    (alu_src),
    .reg2_loc   (reg2_loc),
    .reg_wr     (reg_wr),
    .mem_to_reg (mem_to_reg),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference classification of an instruction word
  function automatic int model_class(input logic [31:0] i);
    logic [10:0] op;
    op = i[31:21];
    if (op == 11'h450 || op == 11'h550 || op == 11'h458 || op == 11'h658) return C_R;
    if (op == 11'h7C2) return C_LD;
    if (op == 11'h7C0) return C_ST;
`ifdef BRANCH_EN
    if (i[31:24] == 8'hB4) return C_CBZ;
    if (i[31:26] == 6'b000101) return C_B;
`endif
    return C_ILL;
  endfunction

  // Reset pulse: async clear checked before any edge, then IDLE, then FETCH
  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instr = 32'h0;
    #1;
    checks++;
    if ({illegal, bus.imem_req, bus.dmem_rd, bus.dmem_wr, pc_wr, reg_wr} !== 6'b0 || dbg_state !== S_IDLE) begin
      fails++;
      $display("FAIL reset_async: outputs=%b state=%0d required 0/IDLE",
               {illegal, bus.imem_req, bus.dmem_rd, bus.dmem_wr, pc_wr, reg_wr}, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.imem_req, bus.dmem_rd, bus.dmem_wr, alu_op, alu_ctl, alu_src, reg2_loc,
         reg_wr, mem_to_reg, pc_wr, pc_src, illegal} !== 22'b0 || dbg_state !== S_IDLE) begin
      fails++;
      $display("FAIL reset_idle: outputs not all 0 in IDLE (state=%0d)", dbg_state);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || dbg_state !== S_FETCH) begin
      fails++;
      $display("FAIL reset_first_fetch: imem_req=%b state=%0d required 1/FETCH", bus.imem_req, dbg_state);
    end
  endtask

  // One instruction from FETCH to the next FETCH (or into TRAP)
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw, input logic zv);
    int cls, cyc, fcnt, mcnt, rd_n, wr_n, rw_n, pw_n, lat, lim;
    logic done, left_fetch, exec_ok, mem_ok, br_ok, ill_seen, ill_end, pcs_seen, m2r_seen, exp_pcs;
    cls = model_class(ins);
    zero_in = zv;
    {cyc, fcnt, mcnt, rd_n, wr_n, rw_n, pw_n} = '0;
    {done, left_fetch, exec_ok, br_ok, ill_seen, ill_end, pcs_seen, m2r_seen} = '0;
    mem_ok = 1'b1;
    lim = (cls == C_ILL) ? 25 : 40;
    checks++;
    if (bus.imem_req !== 1'b1) begin
      fails++;
      $display("FAIL start_in_fetch: imem_req=%b required 1", bus.imem_req);
    end
    for (int k = 0; k < lim && !done; k++) begin
      if (k > 0 && bus.imem_req && left_fetch) done = 1'b1;
      else begin
        if (!bus.imem_req) left_fetch = 1'b1;
        if (bus.imem_req) begin
          bus.imem_ready = (fcnt >= fw);
          bus.instr = bus.imem_ready ? ins : $urandom();
          fcnt++;
        end else begin
          bus.imem_ready = 1'($urandom_range(0, 1));
          bus.instr = $urandom();
        end
        if (bus.dmem_rd || bus.dmem_wr) begin
          bus.dmem_ready = (mcnt >= dw);
          mcnt++;
        end else bus.dmem_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.dmem_rd) rd_n++;
        if (bus.dmem_wr) wr_n++;
        if (bus.dmem_rd || bus.dmem_wr) begin
          if (alu_op !== 2'b00 || alu_src !== 1'b1 || reg2_loc !== (cls == C_ST)) mem_ok = 1'b0;
        end
        if (alu_op === 2'b10 && alu_ctl === ins[31:21] && alu_src === 1'b0) exec_ok = 1'b1;
        if (alu_op === 2'b01 && reg2_loc === 1'b1) br_ok = 1'b1;
        if (reg_wr) begin rw_n++; m2r_seen = mem_to_reg; end
        if (pc_wr) begin pw_n++; pcs_seen = pc_src; end
        if (illegal) ill_seen = 1'b1;
        ill_end = illegal;
        @(negedge clk);
        cyc++;
      end
    end

    if (cls == C_ILL) begin
      checks++;
      if (done) begin
        fails++;
        $display("FAIL trap_no_fetch: imem_req returned for %h", ins);
      end
      checks++;
      if (!(ill_seen && ill_end)) begin
        fails++;
        $display("FAIL trap_illegal: illegal seen=%b at_end=%b required 1/1 for %h", ill_seen, ill_end, ins);
      end
      checks++;
      if (pw_n + rw_n + rd_n + wr_n != 0) begin
        fails++;
        $display("FAIL trap_quiet: pc_wr=%0d reg_wr=%0d rd=%0d wr=%0d required all 0", pw_n, rw_n, rd_n, wr_n);
      end
      do_reset();
      return;
    end

    case (cls)
      C_R:     lat = 4 + fw;
      C_LD:    lat = 5 + fw + dw;
      C_ST:    lat = 4 + fw + dw;
      default: lat = 3 + fw;
    endcase
    exp_pcs = (cls == C_B) || (cls == C_CBZ && zv);

    checks++;
    if (!done || cyc != lat) begin
      fails++;
      $display("FAIL latency: %h got %0d cycles (done=%b) required %0d", ins, cyc, done, lat);
    end
    checks++;
    if (rd_n != ((cls == C_LD) ? dw + 1 : 0) || wr_n != ((cls == C_ST) ? dw + 1 : 0)) begin
      fails++;
      $display("FAIL dmem_len: %h rd=%0d wr=%0d dw=%0d", ins, rd_n, wr_n, dw);
    end
    checks++;
    if (rw_n != ((cls == C_R || cls == C_LD) ? 1 : 0)) begin
      fails++;
      $display("FAIL reg_wr_count: %h got %0d", ins, rw_n);
    end
    checks++;
    if (pw_n != 1 || pcs_seen !== exp_pcs) begin
      fails++;
      $display("FAIL pc_update: %h pc_wr=%0d pc_src=%b required 1/%b", ins, pw_n, pcs_seen, exp_pcs);
    end
    checks++;
    if (ill_seen) begin
      fails++;
      $display("FAIL no_illegal: illegal=1 for legal %h", ins);
    end
    if (rw_n == 1) begin
      checks++;
      if (m2r_seen !== (cls == C_LD)) begin
        fails++;
        $display("FAIL mem_to_reg: %h got %b required %b", ins, m2r_seen, (cls == C_LD));
      end
    end
    if (cls == C_R) begin
      checks++;
      if (!exec_ok) begin
        fails++;
        $display("FAIL exec_rtype: %h no cycle with alu_op=10 alu_ctl=%b alu_src=0", ins, ins[31:21]);
      end
    end
    if (cls == C_LD || cls == C_ST) begin
      checks++;
      if (!mem_ok) begin
        fails++;
        $display("FAIL mem_ctl: %h alu_op/alu_src/reg2_loc not stable during dmem access", ins);
      end
    end
    if (cls == C_CBZ || cls == C_B) begin
      checks++;
      if (!br_ok) begin
        fails++;
        $display("FAIL branch_ctl: %h no cycle with alu_op=01 reg2_loc=1", ins);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    run_instr(32'h8B030041, 0, 0, 1'b0);
  endtask

  task automatic test_ldur_wait();
    run_instr(32'hF8408041, 0, 3, 1'b0);
    run_instr(32'hF8408041, 2, 0, 1'b1);
  endtask

  task automatic test_stur();
    run_instr(32'hF8000041, 0, 0, 1'b0);
    run_instr(32'hF8000041, 1, 2, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(32'hB4000085, 0, 0, 1'b1);
    run_instr(32'hB4000085, 0, 0, 1'b0);
    run_instr(32'h14000004, 0, 0, 1'b0);
  endtask

  task automatic test_trap();
    run_instr(32'h00000000, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_mem();
    logic found;
    found = 1'b0;
    bus.imem_ready = 1'b1;
    bus.instr = 32'hF8000041;
    bus.dmem_ready = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      bus.imem_ready = 1'b0;
      if (bus.dmem_wr) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL mid_mem_reach: dmem_wr never rose within 10 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dmem_wr !== 1'b0 || dbg_state !== S_IDLE) begin
      fails++;
      $display("FAIL mid_mem_abort: dmem_wr=%b state=%0d required 0/IDLE before clock edge", bus.dmem_wr, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_mem_idle: imem_req=%b required 0", bus.imem_req);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_refetch: imem_req=%b required 1", bus.imem_req);
    end
  endtask

  // Random back-to-back instruction stream with random handshake delays
  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [10:0] ops [4];
    ops[0] = 11'h450; ops[1] = 11'h550; ops[2] = 11'h458; ops[3] = 11'h658;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: ins = {11'h000, 21'($urandom())};
        1: ins = {ops[$urandom_range(0, 3)], 21'($urandom())};
        2: ins = {11'h7C2, 21'($urandom())};
        3: ins = {11'h7C0, 21'($urandom())};
        4: ins = {8'hB4, 24'($urandom())};
        default: ins = {6'b000101, 26'($urandom())};
      endcase
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst_n = 1'b0;
    zero_in = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instr = 32'h0;
    test_reset();
    test_add();
    test_ldur_wait();
    test_stur();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/legv8_mc_control.md
LEGV8_MC_CONTROL -- requirements
Module: legv8_mc_control

Interface
REQ-001 SHALL have parameter IW, default 32: instruction width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 imem_req / imem_ready  out/in  1/1  instruction fetch handshake.
REQ-005 instr  in  IW  fetched word, valid when imem_ready is high.
REQ-006 dmem_rd / dmem_wr / dmem_ready  out/out/in  1/1/1  data memory handshake.
REQ-007 zero  in  1  ALU ZERO flag (operand B equals 0).
REQ-008 alu_op  out  2  ALU opcode: 00 add, 01 pass B, 10 use alu_ctl.
REQ-009 alu_ctl  out  11  instruction bits [31:21] fed to the ALU.
REQ-010 alu_src / reg2_loc / reg_wr / mem_to_reg  out  1 each  datapath selects and enables.
REQ-011 pc_wr / pc_src  out  1/1  PC update enable; pc_src 0 selects PC+4, 1 selects branch target.
REQ-012 illegal  out  1  sticky unsupported-opcode flag.

Function
REQ-013 SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP; every output SHALL decode from the state and the registered IR only.
REQ-014 IDLE SHALL drive all outputs 0 and SHALL go to FETCH unconditionally.
REQ-015 FETCH SHALL assert imem_req and hold it until imem_ready is sampled high; on that edge IR SHALL load instr and the FSM SHALL go to DECODE.
REQ-016 DECODE SHALL classify IR[31:21]: AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000 as R-type; LDUR 11111000010; STUR 11111000000. It SHALL classify IR[31:24]=10110100 as CBZ and IR[31:26]=000101 as B.
REQ-017 Transitions from DECODE: R-type/LDUR/STUR to EXEC; CBZ/B to BRANCH; any other opcode to TRAP.
REQ-018 EXEC SHALL drive alu_ctl=IR[31:21]; for R-type it SHALL drive alu_op=10 and alu_src=0 and go to WB; for LDUR/STUR it SHALL drive alu_op=00 and alu_src=1 and go to MEM.
REQ-019 MEM SHALL hold alu_op=00 and alu_src=1 and assert dmem_rd (LDUR) or dmem_wr (STUR) until dmem_ready is sampled high; it SHALL then go to WB for LDUR, or to FETCH with pc_wr=1 and pc_src=0 on the exit cycle for STUR.
REQ-020 STUR SHALL drive reg2_loc=1 in EXEC and MEM.
REQ-021 WB SHALL assert reg_wr=1, pc_wr=1 and pc_src=0, with mem_to_reg=1 only for LDUR, and SHALL go to FETCH.
REQ-022 BRANCH SHALL drive alu_op=01 and reg2_loc=1, assert pc_wr=1, drive pc_src=1 for B or for CBZ when zero=1 and pc_src=0 otherwise, and SHALL go to FETCH.
REQ-023 TRAP SHALL drive illegal=1 with all enables and requests 0, and SHALL remain in TRAP until reset.
REQ-024 Minimum latency with ready tied high SHALL be: R-type 4 cycles, LDUR 5, STUR 4, CBZ/B 3 (FETCH to next FETCH).
REQ-025 A ready input that is high while its request is low SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, IR=0, illegal=0 and all outputs 0, abandoning any pending fetch or data transaction.
REQ-027 The first imem_req SHALL assert in the second cycle after rst_n is released (IDLE, then FETCH).

Configuration
REQ-028 When BRANCH_EN is defined, CBZ and B SHALL decode as specified; when it is undefined, the BRANCH state and its logic SHALL be absent, CBZ and B SHALL go to TRAP, and pc_src SHALL be tied 0.

Structure
REQ-029 The opcode constants, alu_op encodings and state enum SHALL live in package legv8_ctrl_pkg.
REQ-030 Classification SHALL live in a combinational sub-module legv8_op_decode (IR in, class out).

Verification
REQ-031 Reset, then instr 0x8B030041 (ADD) with imem_ready=1 -> IDLE, FETCH, DECODE, then EXEC with alu_op=10 and alu_ctl=10001011000, then WB with reg_wr=1, pc_wr=1, pc_src=0.
REQ-032 LDUR 0xF8408041 with dmem_ready high 3 cycles late -> dmem_rd high for 4 cycles with alu_op=00 and alu_src=1 stable, then WB with mem_to_reg=1.
REQ-033 CBZ 0xB4000085 with zero=1 -> BRANCH with alu_op=01 and pc_src=1; the same instruction with zero=0 -> pc_src=0 and pc_wr=1.
REQ-034 instr 0x00000000 -> TRAP with illegal=1, and imem_req stays 0 for 20 cycles until rst_n pulses low.
REQ-035 rst_n driven low mid-MEM while dmem_wr=1 -> dmem_wr falls without waiting for a clock edge, and the FSM restarts at IDLE.
REQ-036 With BRANCH_EN undefined, B 0x14000004 -> TRAP and illegal=1.
